// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg
//   Shared definitions for the HI/LO sequencer: the request opcode
//   encodings seen on the op port and the sequencer state enum.
package hilo_ctrl_pkg;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN_DIV,
    ST_RUN_MULT,
    ST_CAPTURE
  } state_t;

endpackage

// File: rtl/hilo_ctrl.sv
// hilo_ctrl
//   Sequencer plus architectural HI/LO register pair sitting after the
//   divider and multiplier engines. One request is accepted at a time in
//   IDLE: MULT/DIV latch the operands, launch the relevant engine, wait a
//   fixed latency and capture the results; MTHI/MTLO write HI/LO directly.
//   A DIV with a zero divisor raises div_zero instead of launching.
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low
//   start, op    request strobe (sampled only in IDLE) and opcode
//   op_a, op_b   request operands
//   div_quot/div_rem, mult_hi/mult_lo   engine results
//   eng_a, eng_b latched operands driven to the engines
//   MDControl    divider enable, active-low
//   mult_start   one-cycle multiplier launch pulse
//   busy         a MULT/DIV is in flight
//   done         one-cycle pulse, first cycle new HI/LO are visible
//   div_zero     one-cycle divide-by-zero exception pulse
//   hi, lo       architectural HI/LO registers
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIV_LAT  = 2,
  parameter int MULT_LAT = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  output logic             MDControl,
  output logic             mult_start,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(MULT_LAT + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            hi_we;
  logic            lo_we;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  // Sequencer: accepts requests in IDLE, counts the engine latency in the
  // RUN states and hands over to CAPTURE. MDControl is released on the edge
  // leaving RUN_DIV so the divider sees exactly DIV_LAT enabled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      is_div     <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
      MDControl  <= 1'b1;
      mult_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                eng_a      <= op_a;
                eng_b      <= op_b;
                mult_start <= 1'b1;
                cnt        <= CW'(MULT_LAT - 1);
                is_div     <= 1'b0;
                busy       <= 1'b1;
                state      <= ST_RUN_MULT;
              end
              OP_DIV: begin
                if (op_b == '0) begin
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                end else begin
                  eng_a     <= op_a;
                  eng_b     <= op_b;
                  MDControl <= 1'b0;
                  cnt       <= CW'(DIV_LAT - 1);
                  is_div    <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_RUN_DIV;
                end
              end
              default: begin
                // MTHI/MTLO: the write itself happens in the HI/LO block
                done <= 1'b1;
              end
            endcase
          end
        end
        ST_RUN_DIV, ST_RUN_MULT: begin
          if (cnt == '0) begin
            MDControl <= 1'b1;
            state     <= ST_CAPTURE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_CAPTURE: begin
          MDControl <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write enables and data for HI/LO: direct moves from op_a in IDLE,
  // engine results (divider or multiplier, by launch type) in CAPTURE.
  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_d  = op_a;
    lo_d  = op_a;
    if (state == ST_IDLE && start) begin
      hi_we = (op == OP_MTHI);
      lo_we = (op == OP_MTLO);
    end else if (state == ST_CAPTURE) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      hi_d  = is_div ? div_rem  : mult_hi;
      lo_d  = is_div ? div_quot : mult_lo;
    end
  end

  // HI/LO architectural registers with enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl
//   Directed bench for hilo_ctrl with behavioural divider/multiplier
//   engines. Expected HI/LO/div_zero are pushed to a queue as requests are
//   issued and popped when done is seen.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  localparam int WIDTH    = 32;
  localparam int DIV_LAT  = 2;
  localparam int MULT_LAT = 33;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] div_quot, div_rem, mult_hi, mult_lo;
  logic [WIDTH-1:0] eng_a, eng_b, hi, lo;
  logic             MDControl, mult_start, busy, done, div_zero;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dz;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] m_hi = '0;
  logic [WIDTH-1:0] m_lo = '0;
  int               checks = 0;
  int               passed = 0;
  logic [63:0]      prod;

  hilo_ctrl #(.WIDTH(WIDTH), .DIV_LAT(DIV_LAT), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .div_quot(div_quot), .div_rem(div_rem), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .eng_a(eng_a), .eng_b(eng_b), .MDControl(MDControl), .mult_start(mult_start),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Behavioural engines: results are a pure function of the latched operands.
  assign prod     = {32'b0, eng_a} * {32'b0, eng_b};
  assign mult_hi  = prod[63:32];
  assign mult_lo  = prod[31:0];
  assign div_quot = (eng_b != '0) ? eng_a / eng_b : '0;
  assign div_rem  = (eng_b != '0) ? eng_a % eng_b : '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive a request for one cycle and predict its architectural result.
  task automatic applyStimulus(input logic [1:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    logic [63:0] p;
    logic dz = 1'b0;
    case (o)
      OP_MULT: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_DIV:  if (b == '0) dz = 1'b1; else begin m_lo = a / b; m_hi = a % b; end
      OP_MTHI: m_hi = a;
      default: m_lo = a;
    endcase
    e.hi = m_hi; e.lo = m_lo; e.dz = dz;
    sb.push_back(e);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op_a = 32'h5A5A_5A5A; op_b = 32'hA5A5_A5A5;
  endtask

  task automatic popCompare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_hi"}, 64'(hi), 64'(e.hi));
      checkOutput({tag, "_lo"}, 64'(lo), 64'(e.lo));
      checkOutput({tag, "_div_zero"}, 64'(div_zero), 64'(e.dz));
    end
  endtask

  // Observe cycles from the one after the start edge until done, bounded.
  task automatic runUntilDone(input string tag, input int max_cyc, output int lat,
                              output int md_low, output int busy_cnt, output int ms_cnt);
    lat = -1; md_low = 0; busy_cnt = 0; ms_cnt = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (!MDControl) md_low++;
      if (busy) busy_cnt++;
      if (mult_start) ms_cnt++;
      if (done) begin
        lat = i;
        checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        popCompare(tag);
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) checkOutput({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  // MTHI then MTLO in consecutive cycles, the second issued in the first done cycle.
  task automatic mtPair(input string tag, input logic [WIDTH-1:0] hv, input logic [WIDTH-1:0] lv);
    exp_t e;
    m_hi = hv;
    e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0; sb.push_back(e);
    start = 1'b1; op = OP_MTHI; op_a = hv;
    @(negedge clk);
    checkOutput({tag, "_done1"}, 64'(done), 64'd1);
    checkOutput({tag, "_busy1"}, 64'(busy), 64'd0);
    popCompare({tag, "_mthi"});
    m_lo = lv;
    e.hi = m_hi; e.lo = m_lo; e.dz = 1'b0; sb.push_back(e);
    op = OP_MTLO; op_a = lv;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_done2"}, 64'(done), 64'd1);
    checkOutput({tag, "_busy2"}, 64'(busy), 64'd0);
    popCompare({tag, "_mtlo"});
    @(negedge clk);
    checkOutput({tag, "_done_end"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat, md_low, busy_cnt, ms_cnt, dn;
    reset = 1'b0; start = 1'b0; op = OP_MULT; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    checkOutput("rst_eng_a", 64'(eng_a), 64'd0);
    checkOutput("rst_eng_b", 64'(eng_b), 64'd0);
    checkOutput("rst_mdcontrol", 64'(MDControl), 64'd1);
    checkOutput("rst_outs", 64'({mult_start, busy, done, div_zero}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // DIV 100/7
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    checkOutput("div_eng_a", 64'(eng_a), 64'd100);
    checkOutput("div_eng_b", 64'(eng_b), 64'd7);
    runUntilDone("div", 20, lat, md_low, busy_cnt, ms_cnt);
    checkOutput("div_latency", 64'(lat), 64'(DIV_LAT + 2));
    checkOutput("div_md_low_cycles", 64'(md_low), 64'(DIV_LAT));
    checkOutput("div_no_mult_start", 64'(ms_cnt), 64'd0);

    // Back-to-back moves, issued right in the DIV done cycle
    mtPair("mt_a", 32'hDEAD_BEEF, 32'h0000_1234);
    mtPair("mt_b", 32'd5, 32'd9);

    // Divide by zero
    applyStimulus(OP_DIV, 32'd77, 32'd0);
    checkOutput("dz_mdcontrol", 64'(MDControl), 64'd1);
    runUntilDone("dz", 5, lat, md_low, busy_cnt, ms_cnt);
    checkOutput("dz_latency", 64'(lat), 64'd1);
    checkOutput("dz_busy", 64'(busy_cnt), 64'd0);
    @(negedge clk);
    checkOutput("dz_pulse_end", 64'({done, div_zero}), 64'd0);

    // MULT 0xFFFF_FFFF * 2
    applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    runUntilDone("mult", 60, lat, md_low, busy_cnt, ms_cnt);
    checkOutput("mult_latency", 64'(lat), 64'(MULT_LAT + 2));
    checkOutput("mult_start_pulses", 64'(ms_cnt), 64'd1);
    checkOutput("mult_busy_whole_run", 64'(busy_cnt), 64'(lat - 1));
    checkOutput("mult_md_untouched", 64'(md_low), 64'd0);

    // DIV requested while a MULT is running must be ignored
    @(negedge clk);
    applyStimulus(OP_MULT, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_DIV; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ign_eng_a", 64'(eng_a), 64'd3);
    checkOutput("ign_eng_b", 64'(eng_b), 64'd5);
    runUntilDone("ign", 60, lat, md_low, busy_cnt, ms_cnt);
    checkOutput("ign_md_untouched", 64'(md_low), 64'd0);
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    checkOutput("ign_no_second_op", 64'(dn), 64'd0);

    // Reset pulse in the middle of a DIV
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    checkOutput("rdiv_md_running", 64'(MDControl), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("rdiv_mdcontrol", 64'(MDControl), 64'd1);
    checkOutput("rdiv_busy", 64'(busy), 64'd0);
    checkOutput("rdiv_hilo", 64'({hi, lo}), 64'd0);
    sb.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    checkOutput("rdiv_no_done", 64'(dn), 64'd0);
    checkOutput("rdiv_hilo_after", 64'({hi, lo}), 64'd0);

    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
